reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port integer register file for the RV32 core, next generation of the 2R/1W file.
//  - N read ports, M write ports, configurable width/depth.
//  - After reset, a sweep FSM zeroes the array.
//  - A busy-bit scoreboard tracks registers awaiting long-latency results (GEMM accelerator, loads).
//  - Sits between decode (reads, busy check) and writeback (writes).
// PARAMETERS
//  XLEN   32  data width of each register
//  NREGS  32  number of registers; power of two, >=2; AW = $clog2(NREGS) (localparam)
//  NRD    2   number of read ports
//  NWR    2   number of write ports; higher index has priority on the same address
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  reset        in   1           synchronous, active-low reset
//  wr_en        in   NWR         per-port write enable
//  wr_addr      in   NWR x AW    per-port destination register
//  wr_data      in   NWR x XLEN  per-port write data
//  rd_addr      in   NRD x AW    per-port source register
//  rd_data      out  NRD x XLEN  per-port read data (combinational)
//  rd_busy      out  NRD         1 = source register has a pending writer
//  sb_set_en    in   1           mark sb_set_addr busy (long-latency op issued)
//  sb_set_addr  in   AW          register to mark busy
//  init_done    out  1           1 = sweep complete, file usable
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is synchronous and active-low.
//  - Reset (reset==0 at posedge):
//    - FSM -> INIT, sweep index <= 0, all busy bits <= 0, init_done <= 0.
//    - Array contents are not cleared in the reset cycle itself.
//    - Reset asserted mid-sweep or in RUN restarts the sweep at index 0.
//  - FSM INIT: one register per cycle, mem[idx] <= 0, idx++.
//    - On idx == NREGS-1, go to RUN and set init_done <= 1 the next cycle.
//    - Total: NREGS cycles after reset release.
//    - In INIT: wr_en and sb_set_en are ignored; rd_data = 0; rd_busy = 0.
//  - FSM RUN: stays in RUN until reset.
//  - Writes:
//    - mem[wr_addr[i]] <= wr_data[i] at posedge when wr_en[i] and wr_addr[i] != 0.
//    - Same address on several ports: the highest i wins; the others are dropped.
//  - Reads:
//    - rd_data[j] = (rd_addr[j]==0) ? 0 : mem[rd_addr[j]], zero-latency combinational.
//    - rd_busy[j] = busy[rd_addr[j]].
//  - Register x0: always reads 0, never written, never busy; sb_set with addr 0 is ignored.
//  - Scoreboard:
//    - busy[a] <= 1 on sb_set_en with addr a.
//    - busy[a] <= 0 on any wr_en[i] with wr_addr[i] == a.
//    - Set and clear of the same a in one cycle: set wins (a new writer was issued).
//  - Read/write same address in one cycle: governed by REGFILE_BYPASS_EN (below).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - Each read port forwards wr_data of the highest-index port writing its nonzero rd_addr this cycle.
//   - rd_busy for that port reads 0, unless sb_set_en targets the same address this cycle.
//  REGFILE_BYPASS_EN undefined:
//   - Reads return the pre-write array value.
//   - rd_busy reflects the registered busy bit; the new value is visible next cycle.
// STRUCTURE
//  - Package rf_pkg: XLEN_DEFAULT, NREGS_DEFAULT, rf_state_e {RF_INIT, RF_RUN},
//    reg index typedef rf_idx_t (logic [AW-1:0] for default NREGS).
//  - Sub-module rf_scoreboard: busy-bit vector with set/clear ports and set-wins priority,
//    NREGS-bit; instantiated once.
//  - Top level: array, write-priority mux, read mux/bypass, INIT FSM.
// TESTING
//  - Reset sweep: hold reset=0 2 cycles, release -> init_done rises exactly NREGS(32) cycles later;
//    every register reads 0; writes issued during INIT are lost.
//  - Basic R/W: write x5=0xDEADBEEF on port 0 -> next cycle both read ports on x5 return 0xDEADBEEF;
//    write x0=0x1234 -> x0 reads 0.
//  - Write conflict: port0 x7=0x11, port1 x7=0x22 same cycle -> x7 reads 0x22.
//  - Scoreboard:
//    - sb_set x9 -> rd_busy=1 next cycle.
//    - Write x9=0x55 -> busy clears next cycle.
//    - sb_set x9 together with a write to x9 -> busy stays 1.
//    - sb_set x0 -> rd_busy stays 0.
//  - Bypass: read x3 (holding 0xA) while writing 0xB in the same cycle
//    -> 0xB with REGFILE_BYPASS_EN, 0xA without; both builds read 0xB the next cycle.
//  - Mid-op reset: reset=0 in RUN with busy bits set -> busy all 0, init_done=0, sweep restarts at index 0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package rf_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_e;

    typedef logic [AW_DEFAULT-1:0] rf_idx_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bundle of the register file: write ports, read ports,
// scoreboard set port and init status.
interface reg_file_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic                     sb_set_en;
    logic [AW-1:0]            sb_set_addr;
    logic                     init_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, init_done
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Busy-bit vector for registers awaiting long-latency results; set beats clear.
module rf_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREGS-1:0] set_vec,
    input  logic [NREGS-1:0] clr_vec,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_d;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        busy_d    = (busy & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// NRD-read / NWR-write integer register file with post-reset zeroing sweep and busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    rf_state_e                state;
    logic [AW-1:0]            idx;
    logic                     init_done_q;
    logic                     run;
    logic [XLEN-1:0]          mem [NREGS];
    logic [NREGS-1:0]         set_vec;
    logic [NREGS-1:0]         clr_vec;
    logic [NREGS-1:0]         busy;
    logic [NRD-1:0][XLEN-1:0] rd_data_c;
    logic [NRD-1:0]           rd_busy_c;

    assign run = (state == RF_RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RF_INIT;
            idx         <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                RF_INIT: begin
                    if (idx == AW'(NREGS - 1)) begin
                        state       <= RF_RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RF_RUN: state <= RF_RUN;
                default: state <= RF_INIT;
            endcase
        end
    end

    // NOTE: the array has no reset branch; the sweep clears it so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (!run) begin
                mem[idx] <= '0;
            end else begin
                // Later ports overwrite earlier ones, giving the highest index priority.
                for (int i = 0; i < NWR; i++) begin
                    if (bus.wr_en[i] && bus.wr_addr[i] != '0) begin
                        mem[bus.wr_addr[i]] <= bus.wr_data[i];
                    end
                end
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (run) begin
            if (bus.sb_set_en) set_vec[bus.sb_set_addr] = 1'b1;
            for (int i = 0; i < NWR; i++) begin
                if (bus.wr_en[i]) clr_vec[bus.wr_addr[i]] = 1'b1;
            end
        end
    end

    rf_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_vec (set_vec),
        .clr_vec (clr_vec),
        .busy    (busy)
    );

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int j = 0; j < NRD; j++) begin
            if (run && bus.rd_addr[j] != '0) begin
                rd_data_c[j] = mem[bus.rd_addr[j]];
                rd_busy_c[j] = busy[bus.rd_addr[j]];
`ifdef REGFILE_BYPASS_EN
                // A writer landing this cycle supersedes the stored value and retires the busy bit,
                // unless a new long-latency writer is issued to the same register right now.
                for (int i = 0; i < NWR; i++) begin
                    if (bus.wr_en[i] && bus.wr_addr[i] == bus.rd_addr[j]) begin
                        rd_data_c[j] = bus.wr_data[i];
                        rd_busy_c[j] = set_vec[bus.rd_addr[j]];
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.rd_busy   = rd_busy_c;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard-based bench for reg_file_mp: sweep, R/W, conflicts, busy bits, bypass, mid-op reset.
module tb_reg_file_mp;

    localparam int NREGS = 32;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    logic clk;
    logic reset;

    reg_file_mp_if #(.XLEN(32), .NREGS(NREGS), .NRD(2), .NWR(2)) bus ();

    reg_file_mp #(.XLEN(32), .NREGS(NREGS), .NRD(2), .NWR(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        q[$];
    logic [31:0] m_mem  [NREGS];
    logic        m_busy [NREGS];

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic drive(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic sbe, input logic [4:0] sba);
        bus.wr_en       = {we1, we0};
        bus.wr_addr     = {wa1, wa0};
        bus.wr_data     = {wd1, wd0};
        bus.rd_addr     = {ra1, ra0};
        bus.sb_set_en   = sbe;
        bus.sb_set_addr = sba;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ra0, ra1, 1'b0, 5'd0);
    endtask

    function automatic exp_t model_read(input int port);
        exp_t        e;
        logic [4:0]  ra;
        ra     = bus.rd_addr[port];
        e.port = port;
        e.data = (ra == 5'd0) ? 32'h0 : m_mem[ra];
        e.busy = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (ra != 5'd0) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.wr_en[i] && bus.wr_addr[i] == ra) begin
                    e.data = bus.wr_data[i];
                    e.busy = bus.sb_set_en && (bus.sb_set_addr == ra);
                end
            end
        end
`endif
        return e;
    endfunction

    task automatic model_commit();
        for (int i = 0; i < 2; i++) begin
            if (bus.wr_en[i] && bus.wr_addr[i] != 5'd0) m_mem[bus.wr_addr[i]] = bus.wr_data[i];
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.wr_en[i]) m_busy[bus.wr_addr[i]] = 1'b0;
        end
        if (bus.sb_set_en && bus.sb_set_addr != 5'd0) m_busy[bus.sb_set_addr] = 1'b1;
    endtask

    // Called at a negedge with inputs driven; checks both read ports, then advances one cycle.
    task automatic step(input string tag);
        exp_t e;
        q.push_back(model_read(0));
        q.push_back(model_read(1));
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.rd_data[e.port] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
                n_err++;
                $display("FAIL %s port%0d x%0d: got data=%h busy=%b, expected data=%h busy=%b",
                         tag, e.port, bus.rd_addr[e.port], bus.rd_data[e.port],
                         bus.rd_busy[e.port], e.data, e.busy);
            end
        end
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // Reset must just have been released at a negedge; counts posedges until init_done rises.
    task automatic wait_init(input string tag);
        int cyc = 0;
        while (bus.init_done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.init_done !== 1'b1) begin
                n_cmp++;
                if (bus.rd_data !== '0 || bus.rd_busy !== '0) begin
                    n_err++;
                    $display("FAIL %s_init_reads cycle %0d: got data=%h busy=%b, expected all zero",
                             tag, cyc, bus.rd_data, bus.rd_busy);
                end
            end
        end
        n_cmp++;
        if (cyc != NREGS) begin
            n_err++;
            $display("FAIL %s_latency: init_done after %0d cycles, expected %0d", tag, cyc, NREGS);
        end
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 5'd5, 32'h99, 1'b1, 5'd6, 32'h77, 5'd5, 5'd6, 1'b1, 5'd6);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.init_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init_done: got %b, expected 0", bus.init_done);
        end
        reset = 1'b1;
        wait_init("reset");
        for (int r = 0; r < NREGS; r += 2) begin
            idle(5'(r), 5'(r + 1));
            step("sweep_zero");
        end
    endtask

    task automatic test_basic_rw();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
        step("rw_write_x5");
        idle(5'd5, 5'd5);
        step("rw_read_x5");
        drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0);
        step("rw_write_x0");
        idle(5'd0, 5'd0);
        step("rw_read_x0");
    endtask

    task automatic test_conflict();
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7, 5'd6, 1'b0, 5'd0);
        step("conflict_write");
        idle(5'd7, 5'd7);
        step("conflict_read");
    endtask

    task automatic test_scoreboard();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
        step("sb_set_x9");
        idle(5'd9, 5'd9);
        step("sb_busy_x9");
        drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8, 1'b0, 5'd0);
        step("sb_write_x9");
        idle(5'd9, 5'd9);
        step("sb_cleared_x9");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h66, 5'd9, 5'd9, 1'b1, 5'd9);
        step("sb_set_and_write_x9");
        idle(5'd9, 5'd9);
        step("sb_set_wins_x9");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd0);
        step("sb_set_x0");
        idle(5'd0, 5'd0);
        step("sb_x0_not_busy");
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0);
        step("bypass_prefill");
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hB, 5'd3, 5'd3, 1'b0, 5'd0);
        step("bypass_same_cycle");
        idle(5'd3, 5'd3);
        step("bypass_next_cycle");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 80; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            step("b2b_random");
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0, 32'h0, 5'd12, 5'd13, 1'b1, 5'd12);
        step("mid_set_x12");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd13, 1'b1, 5'd13);
        step("mid_set_x13");
        idle(5'd12, 5'd13);
        step("mid_busy_before_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.init_done !== 1'b0 || bus.rd_busy !== 2'b00 || bus.rd_data !== '0) begin
            n_err++;
            $display("FAIL mid_reset_state: got init_done=%b busy=%b data=%h, expected 0/00/0",
                     bus.init_done, bus.rd_busy, bus.rd_data);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_init("mid_reset");
        idle(5'd12, 5'd13);
        step("mid_after_sweep");
        idle(5'd5, 5'd9);
        step("mid_after_sweep_old");
    endtask

    initial begin
        reset = 1'b0;
        idle(5'd0, 5'd0);
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic_rw();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
